// File: rtl/spi_cfg_arbiter.sv
// spi_cfg_arbiter: round-robin sharing of one spi_module master between a config sequencer (port 0) and a host path (port 1)
// Ports: clk/rst (async, active high); reqN_valid_i/reqN_data_i/reqN_ready_o accept words, rspN_valid_o/rspN_data_o
// return replies; spi_sdo_* issue the word, spi_sdi_* take the reply; busy_o, grant_o (last owner), timeout_o.
// Optional feature: define SPI_CFG_TIMEOUT_EN to bound WAIT_RSP by TIMEOUT_CYCLES and answer with all-ones on expiry.
module spi_cfg_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  output logic                  rsp0_valid_o,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  spi_sdo_valid_o,
  output logic [DATA_WIDTH-1:0] spi_sdo_data_o,
  input  logic                  spi_sdo_ready_i,
  input  logic                  spi_sdi_valid_i,
  input  logic [DATA_WIDTH-1:0] spi_sdi_data_i,
  output logic                  spi_sdi_ready_o,
  output logic                  busy_o,
  output logic                  grant_o,
  output logic                  timeout_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, GAP} state_t;
  localparam int GW = $clog2(GAP_CYCLES > 1 ? GAP_CYCLES : 1) + 1;
  state_t                  state;
  logic [GW-1:0]           gap_cnt;
  logic [DATA_WIDTH-1:0]   word;
  logic                    win0, win1, got, t_exp, done;
  logic [DATA_WIDTH-1:0]   rsp_word;
  always_comb begin
    win0         = req0_valid_i && (!req1_valid_i || grant_o);
    win1         = req1_valid_i && (!req0_valid_i || !grant_o);
    req0_ready_o = (state == IDLE) && win0;
    req1_ready_o = (state == IDLE) && win1;
    got          = (state == WAIT_RSP) && spi_sdi_valid_i;
    done         = got || t_exp;
    rsp_word     = got ? spi_sdi_data_i : '1;
  end
  assign spi_sdo_valid_o = state == ISSUE;
  assign spi_sdi_ready_o = state == WAIT_RSP;
  assign spi_sdo_data_o  = word;
  assign busy_o          = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      word         <= '0;
      grant_o      <= 1'b1;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp0_data_o  <= '0;
      rsp1_data_o  <= '0;
    end else begin
      rsp0_valid_o <= done && !grant_o;
      rsp1_valid_o <= done && grant_o;
      if (done && !grant_o) rsp0_data_o <= rsp_word;
      if (done && grant_o) rsp1_data_o <= rsp_word;
      case (state)
        IDLE: if (win0 || win1) begin
          word    <= win1 ? req1_data_i : req0_data_i;
          grant_o <= win1;
          state   <= ISSUE;
        end
        ISSUE: if (spi_sdo_ready_i) state <= WAIT_RSP;
        WAIT_RSP: if (done) begin
          gap_cnt <= GW'(GAP_CYCLES);
          state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPI_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES : 1) + 1;
  logic [TW-1:0] t_cnt;
  assign t_exp = (state == WAIT_RSP) && !spi_sdi_valid_i && (t_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= t_exp;
      t_cnt     <= (state == WAIT_RSP) ? t_cnt + 1'b1 : '0;
    end
  end
`else
  assign t_exp     = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// tb_spi_cfg_arbiter: directed stimulus with a reply scoreboard checked by an independent monitor
module tb_spi_cfg_arbiter;
  typedef struct packed {logic port; logic to; logic [31:0] data;} exp_t;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, sdo_ready = 0, sdi_valid = 0;
  logic [31:0] req0_data = 0, req1_data = 0, sdi_data = 0;
  logic req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o;
  logic [31:0] rsp0_data_o, rsp1_data_o, spi_sdo_data_o;
  logic spi_sdo_valid_o, spi_sdi_ready_o, busy_o, grant_o, timeout_o;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  spi_cfg_arbiter #(.DATA_WIDTH(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready_o),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o),
    .spi_sdo_valid_o(spi_sdo_valid_o), .spi_sdo_data_o(spi_sdo_data_o), .spi_sdo_ready_i(sdo_ready),
    .spi_sdi_valid_i(sdi_valid), .spi_sdi_data_i(sdi_data), .spi_sdi_ready_o(spi_sdi_ready_o),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic port, input logic to, input logic [31:0] data);
    exp_t r;
    r.port = port;
    r.to   = to;
    r.data = data;
    return r;
  endfunction
  always @(negedge clk) begin
    if (rsp0_valid_o || rsp1_valid_o) begin
      if (sb.size() == 0) chk("rsp_unexpected", {30'd0, rsp1_valid_o, rsp0_valid_o}, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_port", {30'd0, rsp1_valid_o, rsp0_valid_o}, e.port ? 2 : 1);
        chk("rsp_data", e.port ? rsp1_data_o : rsp0_data_o, e.data);
        chk("rsp_timeout", timeout_o, e.to);
      end
    end else if (timeout_o) chk("timeout_stray", timeout_o, 0);
  end
  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_grant"}, grant_o, 1);
    chk({tag, "_sdo_valid"}, spi_sdo_valid_o, 0);
    chk({tag, "_sdo_data"}, spi_sdo_data_o, 0);
    chk({tag, "_sdi_ready"}, spi_sdi_ready_o, 0);
    chk({tag, "_rsp_valid"}, {rsp1_valid_o, rsp0_valid_o}, 0);
    chk({tag, "_rsp0_data"}, rsp0_data_o, 0);
    chk({tag, "_rsp1_data"}, rsp1_data_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask
  task automatic send(input logic port, input logic [31:0] d);
    int n = 0;
    if (port) begin req1_valid = 1; req1_data = d; end
    else begin req0_valid = 1; req0_data = d; end
    while (n < 50) begin
      @(negedge clk);
      if (port ? req1_ready_o : req0_ready_o) break;
      n++;
    end
    chk("accept_in_time", n < 50, 1);
    @(posedge clk); #1;
    if (port) req1_valid = 0; else req0_valid = 0;
  endtask
  task automatic wait_sdo(input logic [31:0] w);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (spi_sdo_valid_o) break;
      n++;
    end
    chk("sdo_valid_in_time", n < 50, 1);
    chk("sdo_data", spi_sdo_data_o, w);
  endtask
  task automatic sdo_handshake();
    @(posedge clk); #1 sdo_ready = 1;
    @(posedge clk); #1 sdo_ready = 0;
  endtask
  task automatic serve(input logic [31:0] w, input int dly, input logic [31:0] reply);
    wait_sdo(w);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("stall_valid", spi_sdo_valid_o, 1);
      chk("stall_data", spi_sdo_data_o, w);
      chk("stall_ready", {req1_ready_o, req0_ready_o}, 0);
    end
    sdo_handshake();
    @(negedge clk);
    chk("sdi_ready", spi_sdi_ready_o, 1);
    chk("sdo_valid_drop", spi_sdo_valid_o, 0);
    @(posedge clk); #1 sdi_valid = 1; sdi_data = reply;
    @(posedge clk); #1 sdi_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    reset_checks("rst");
    @(posedge clk); #1 rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [31:0] a0, b1;
    @(negedge clk);
    reset_checks("por");
    @(posedge clk); #1 rst = 0;
    sb.push_back(mk(0, 0, 32'h12345678));
    send(0, 32'h0000_00AB);
    serve(32'h0000_00AB, 3, 32'h12345678);
    req0_valid = 1; req0_data = 32'h0000_0055;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req0_ready_o) break;
      chk("gap_busy", busy_o, 1);
      n++;
    end
    chk("gap_cycles", n, 4);
    @(posedge clk); #1 req0_valid = 0;
    sb.push_back(mk(0, 0, 32'hCAFE_0001));
    serve(32'h0000_0055, 0, 32'hCAFE_0001);
    repeat (8) @(posedge clk);
    #1;
    do_reset();
    a0 = 32'hA0A0_0000; b1 = 32'hB1B1_0001;
    req0_valid = 1; req0_data = a0; req1_valid = 1; req1_data = b1;
    @(negedge clk);
    chk("contend_ready", {req1_ready_o, req0_ready_o}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(k[0], 0, 32'h1000_0000 + k));
      serve(k[0] ? b1 : a0, 1, 32'h1000_0000 + k);
      chk("contend_grant", grant_o, k[0]);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    req1_valid = 1; req1_data = 32'h0000_00B2;
    sb.push_back(mk(0, 0, 32'hDEAD_BEEF));
    send(0, 32'h0000_00C4);
    serve(32'h0000_00C4, 10, 32'hDEAD_BEEF);
    req1_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    send(0, 32'h0000_0077);
    wait_sdo(32'h0000_0077);
    sdo_handshake();
    @(negedge clk);
    chk("pre_rst_sdi_ready", spi_sdi_ready_o, 1);
    chk("pre_rst_grant", grant_o, 0);
    #2 rst = 1; sdi_valid = 1; sdi_data = 32'h0BAD_0BAD;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_grant", grant_o, 1);
    chk("async_sdi_ready", spi_sdi_ready_o, 0);
    @(posedge clk); #1 sdi_valid = 0;
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_rsp0_data", rsp0_data_o, 0);
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'h0000_0088; req1_valid = 1; req1_data = 32'h0000_0099;
    @(negedge clk);
    chk("post_rst_ready", {req1_ready_o, req0_ready_o}, 2'b01);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    sb.push_back(mk(0, 0, 32'h5A5A_0088));
    serve(32'h0000_0088, 0, 32'h5A5A_0088);
    repeat (8) @(posedge clk);
    #1;
`ifdef SPI_CFG_TIMEOUT_EN
    sb.push_back(mk(1, 1, 32'hFFFF_FFFF));
    send(1, 32'h0000_0066);
    wait_sdo(32'h0000_0066);
    sdo_handshake();
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (rsp1_valid_o) break;
      n++;
    end
    chk("timeout_latency", n, 16);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("timeout_idle", busy_o, 0);
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
